// File: rtl/systolic_gemm_engine.sv
// Output-stationary ARRAY_SIZE x ARRAY_SIZE systolic GEMM: C = A*B in fixed point, with
// skewed operand feed, shift/saturate conversion, optional ReLU and cross-run accumulation.
module systolic_gemm_engine #(
    parameter int ARRAY_SIZE   = 2,
    parameter int K_DEPTH      = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32,
    parameter int FRAC_SHIFT   = 6
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    input  logic                                     acc_en,
    input  logic                                     relu_en,
    input  logic [DATA_WIDTH*ARRAY_SIZE*K_DEPTH-1:0]   matrix_a_flat,
    input  logic [WEIGHT_WIDTH*K_DEPTH*ARRAY_SIZE-1:0] matrix_b_flat,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     result_valid,
    output logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result_flat,
    output logic                                     overflow
);

    localparam int N              = ARRAY_SIZE;
    localparam int K              = K_DEPTH;
    localparam int PW             = DATA_WIDTH + WEIGHT_WIDTH;
    localparam int COMPUTE_CYCLES = K + 2 * N - 2;
    localparam int CW             = $clog2(COMPUTE_CYCLES + 1);
    localparam logic signed [ACCUM_WIDTH-1:0] SAT_MAX =
        {{(ACCUM_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, COMPUTE, CONVERT} state_t;
    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0]   a_cap  [N][K];
    logic signed [WEIGHT_WIDTH-1:0] b_cap  [K][N];
    logic signed [DATA_WIDTH-1:0]   a_pipe [N][N];
    logic signed [WEIGHT_WIDTH-1:0] b_pipe [N][N];
    logic signed [DATA_WIDTH-1:0]   a_in   [N][N];
    logic signed [WEIGHT_WIDTH-1:0] b_in   [N][N];
    logic signed [PW-1:0]           prod   [N][N];
    logic signed [ACCUM_WIDTH-1:0]  acc    [N][N];
    logic signed [DATA_WIDTH-1:0]   feed_a [N];
    logic signed [WEIGHT_WIDTH-1:0] feed_b [N];
    logic signed [ACCUM_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]          elem;
    logic [DATA_WIDTH*N*N-1:0]      conv_flat;
    logic [CW-1:0]                  cnt;
    logic                           relu_q;
    logic                           accept;
    logic                           last_compute;
    logic                           any_sat;

    // The done cycle is already IDLE, but a start there must still be ignored.
    assign accept       = (state_q == IDLE) && start && !done;
    assign last_compute = (cnt == CW'(COMPUTE_CYCLES - 1));
    assign busy         = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = COMPUTE;
            COMPUTE: if (last_compute) state_d = CONVERT;
            CONVERT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Edge feeds: row i gets A[i][cnt-i], column j gets B[cnt-j][j], zero outside the matrix.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            feed_a[i] = '0;
            feed_b[i] = '0;
            for (int k = 0; k < K; k++) begin
                if (int'(cnt) == i + k) feed_a[i] = a_cap[i][k];
                if (int'(cnt) == i + k) feed_b[i] = b_cap[k][i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = feed_a[i];
            b_in[0][i] = feed_b[i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_pipe[i][j-1];
                b_in[j][i] = b_pipe[j-1][i];
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                prod[i][j] = PW'(a_in[i][j]) * PW'(b_in[i][j]);
    end

    always_comb begin
        conv_flat = '0;
        any_sat   = 1'b0;
        shifted   = '0;
        elem      = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                shifted = acc[i][j] >>> FRAC_SHIFT;
                if (shifted > SAT_MAX) begin
                    elem    = SAT_MAX[DATA_WIDTH-1:0];
                    any_sat = 1'b1;
                end else if (shifted < SAT_MIN) begin
                    elem    = SAT_MIN[DATA_WIDTH-1:0];
                    any_sat = 1'b1;
                end else begin
                    elem = shifted[DATA_WIDTH-1:0];
                end
                if (relu_q && elem[DATA_WIDTH-1]) elem = '0;
                conv_flat[(i*N+j)*DATA_WIDTH +: DATA_WIDTH] = elem;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            relu_q       <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            result_flat  <= '0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < K; k++) begin
                    a_cap[i][k] <= '0;
                    b_cap[k][i] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt          <= '0;
                        relu_q       <= relu_en;
                        result_valid <= 1'b0;
                        overflow     <= 1'b0;
                        for (int i = 0; i < N; i++) begin
                            for (int k = 0; k < K; k++) begin
                                a_cap[i][k] <= matrix_a_flat[(i*K+k)*DATA_WIDTH +: DATA_WIDTH];
                                b_cap[k][i] <= matrix_b_flat[(k*N+i)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                            end
                            for (int j = 0; j < N; j++) begin
                                a_pipe[i][j] <= '0;
                                b_pipe[i][j] <= '0;
                                if (!acc_en) acc[i][j] <= '0;
                            end
                        end
                    end
                end
                COMPUTE: begin
                    cnt <= cnt + CW'(1);
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            a_pipe[i][j] <= a_in[i][j];
                            b_pipe[i][j] <= b_in[i][j];
                            acc[i][j]    <= acc[i][j] + ACCUM_WIDTH'(prod[i][j]);
                        end
                    end
                end
                CONVERT: begin
                    result_flat  <= conv_flat;
                    result_valid <= 1'b1;
                    overflow     <= any_sat;
                    done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_gemm_engine.sv
// Self-checking bench for systolic_gemm_engine: directed vectors plus randomized runs
// compared against a plain-arithmetic matrix-multiply reference model.
module tb_systolic_gemm_engine;

    localparam int N       = 2;
    localparam int K       = 2;
    localparam int DW      = 16;
    localparam int WW      = 8;
    localparam int FS      = 6;
    localparam int A_BITS  = DW * N * K;
    localparam int B_BITS  = WW * K * N;
    localparam int C_BITS  = DW * N * N;
    localparam int LATENCY = K + 2 * N;
    localparam int MAXV    = (1 << (DW - 1)) - 1;
    localparam int MINV    = -(1 << (DW - 1));

    localparam logic [A_BITS-1:0] ID_A = 64'h0400_0000_0000_0400;
    localparam logic [B_BITS-1:0] ID_B = 32'h4000_0040;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              acc_en;
    logic              relu_en;
    logic [A_BITS-1:0] matrix_a_flat;
    logic [B_BITS-1:0] matrix_b_flat;
    logic              busy;
    logic              done;
    logic              result_valid;
    logic [C_BITS-1:0] result_flat;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    int                model_acc [N][N];
    logic [C_BITS-1:0] exp_result;
    logic              exp_overflow;

    systolic_gemm_engine #(
        .ARRAY_SIZE(N), .K_DEPTH(K), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW),
        .ACCUM_WIDTH(32), .FRAC_SHIFT(FS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc_en(acc_en), .relu_en(relu_en),
        .matrix_a_flat(matrix_a_flat), .matrix_b_flat(matrix_b_flat),
        .busy(busy), .done(done), .result_valid(result_valid),
        .result_flat(result_flat), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: C = A*B summed in 32-bit, then >>> FS, clamp to DW bits, optional ReLU.
    task automatic modelRun(input logic [A_BITS-1:0] a, input logic [B_BITS-1:0] b,
                            input logic acc, input logic relu);
        int sh;
        exp_overflow = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!acc) model_acc[i][j] = 0;
                for (int k = 0; k < K; k++)
                    model_acc[i][j] += int'($signed(a[(i*K+k)*DW +: DW])) *
                                       int'($signed(b[(k*N+j)*WW +: WW]));
                sh = model_acc[i][j] >>> FS;
                if (sh > MAXV) begin
                    sh = MAXV;
                    exp_overflow = 1'b1;
                end else if (sh < MINV) begin
                    sh = MINV;
                    exp_overflow = 1'b1;
                end
                if (relu && sh < 0) sh = 0;
                exp_result[(i*N+j)*DW +: DW] = sh[DW-1:0];
            end
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_valid"}, result_valid, 1'b0);
        checkOutput({tag, "_overflow"}, overflow, 1'b0);
        checkOutput({tag, "_result"}, result_flat, '0);
    endtask

    // One full run: accept, scramble inputs, optionally poke start mid-run, then check results.
    task automatic applyStimulus(input logic [A_BITS-1:0] a, input logic [B_BITS-1:0] b,
                                 input logic acc, input logic relu, input string tag,
                                 input bit poke);
        int cycles;
        int busy_drops;
        bit seen;
        matrix_a_flat = a;
        matrix_b_flat = b;
        acc_en        = acc;
        relu_en       = relu;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        modelRun(a, b, acc, relu);
        matrix_a_flat = {$urandom, $urandom};
        matrix_b_flat = $urandom;
        acc_en        = 1'($urandom);
        relu_en       = 1'($urandom);
        checkOutput({tag, "_busy_after_start"}, busy, 1'b1);
        checkOutput({tag, "_valid_cleared"}, result_valid, 1'b0);
        seen       = 1'b0;
        cycles     = 0;
        busy_drops = 0;
        for (int c = 2; c <= 60 && !seen; c++) begin
            start = (poke && c == 3);
            @(posedge clk); #1;
            if (done) begin
                seen   = 1'b1;
                cycles = c;
            end else if (!busy) begin
                busy_drops++;
            end
        end
        start = 1'b0;
        checkOutput({tag, "_done_seen"}, seen, 1'b1);
        if (seen) begin
            checkOutput({tag, "_latency"}, cycles, LATENCY);
            checkOutput({tag, "_busy_drops"}, busy_drops, 0);
            checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
            checkOutput({tag, "_result"}, result_flat, exp_result);
            checkOutput({tag, "_valid"}, result_valid, 1'b1);
            checkOutput({tag, "_overflow"}, overflow, exp_overflow);
            @(posedge clk); #1;
            checkOutput({tag, "_done_pulse"}, done, 1'b0);
            @(posedge clk); #1;
            checkOutput({tag, "_hold_result"}, result_flat, exp_result);
            checkOutput({tag, "_hold_valid"}, result_valid, 1'b1);
        end
    endtask

    function automatic logic [A_BITS-1:0] smallA();
        logic [A_BITS-1:0] v;
        for (int e = 0; e < N * K; e++)
            v[e*DW +: DW] = DW'($urandom_range(0, 4095) - 2048);
        return v;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_count;
        int busy_count;
        logic [A_BITS-1:0] a;

        rst_n = 1'b0;
        start = 1'b0;
        acc_en = 1'b0;
        relu_en = 1'b0;
        matrix_a_flat = '0;
        matrix_b_flat = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                model_acc[i][j] = 0;
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        applyStimulus(ID_A, ID_B, 1'b0, 1'b0, "identity", 1'b0);
        checkOutput("identity_const", result_flat, 64'h0400_0000_0000_0400);
        applyStimulus(ID_A, ID_B, 1'b1, 1'b0, "accumulate", 1'b1);
        checkOutput("accumulate_const", result_flat, 64'h0800_0000_0000_0800);
        applyStimulus({4{16'h7FFF}}, {4{8'h7F}}, 1'b0, 1'b0, "saturate", 1'b0);
        checkOutput("saturate_const", result_flat, {4{16'h7FFF}});
        checkOutput("saturate_overflow", overflow, 1'b1);
        applyStimulus(64'h0000_0000_0000_FC00, ID_B, 1'b0, 1'b0, "relu_off", 1'b0);
        checkOutput("relu_off_c00", result_flat[15:0], 16'hFC00);
        applyStimulus(64'h0000_0000_0000_FC00, ID_B, 1'b0, 1'b1, "relu_on", 1'b0);
        checkOutput("relu_on_c00", result_flat[15:0], 16'h0000);

        // Randomized runs, mixing full-range and small operands
        for (int r = 0; r < 24; r++) begin
            a = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : smallA();
            applyStimulus(a, $urandom, 1'($urandom), 1'($urandom),
                          $sformatf("rand%0d", r), 1'($urandom));
        end

        // Start held high for 10 edges: accepts at edge 0 and edge 7 only
        matrix_a_flat = ID_A;
        matrix_b_flat = ID_B;
        acc_en        = 1'b0;
        relu_en       = 1'b0;
        start         = 1'b1;
        done_count    = 0;
        busy_count    = 0;
        for (int s = 0; s <= 12; s++) begin
            @(posedge clk); #1;
            if (s == 0 || s == 7) modelRun(ID_A, ID_B, 1'b0, 1'b0);
            if (s == 9) start = 1'b0;
            if (done) done_count++;
            if (busy) busy_count++;
        end
        checkOutput("hold_done_count", done_count, 2);
        checkOutput("hold_busy_count", busy_count, 10);
        checkOutput("hold_result", result_flat, exp_result);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of COMPUTE, then a fresh accumulating identity run
        matrix_a_flat = ID_A;
        matrix_b_flat = ID_B;
        acc_en        = 1'b1;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                model_acc[i][j] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(ID_A, ID_B, 1'b1, 1'b0, "post_reset", 1'b0);
        checkOutput("post_reset_const", result_flat, 64'h0400_0000_0000_0400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_gemm_engine.md
SYSTOLIC_GEMM_ENGINE -- requirements
Module: systolic_gemm_engine

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 2: PE rows and columns; output tile is ARRAY_SIZE x ARRAY_SIZE.
REQ-002 SHALL have parameter K_DEPTH, default 2: inner (reduction) dimension, K_DEPTH >= 1.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: signed Q5.10 activation and result element width.
REQ-004 SHALL have parameter WEIGHT_WIDTH, default 8: signed Q1.6 weight element width.
REQ-005 SHALL have parameter ACCUM_WIDTH, default 32: signed PE accumulator width.
REQ-006 SHALL have parameter FRAC_SHIFT, default 6: right-shift applied when converting the accumulator to a result element.
REQ-007 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1: request a GEMM run.
REQ-010 SHALL have port acc_en, input, 1: sampled with start; 1 keeps prior accumulators, 0 clears them.
REQ-011 SHALL have port relu_en, input, 1: sampled with start; 1 clamps negative results to 0.
REQ-012 SHALL have port matrix_a_flat, input, DATA_WIDTH*ARRAY_SIZE*K_DEPTH: A[i][k] at bits [(i*K_DEPTH+k)*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port matrix_b_flat, input, WEIGHT_WIDTH*K_DEPTH*ARRAY_SIZE: B[k][j] at bits [(k*ARRAY_SIZE+j)*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-014 SHALL have port busy, output, 1: high from the cycle after start is accepted until done.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when results are published.
REQ-016 SHALL have port result_valid, output, 1: level; high while result_flat holds a completed run.
REQ-017 SHALL have port result_flat, output, DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE: C[i][j] at bits [(i*ARRAY_SIZE+j)*DATA_WIDTH +: DATA_WIDTH].
REQ-018 SHALL have port overflow, output, 1: set if any element of the last run saturated.

Function
REQ-019 SHALL implement FSM IDLE -> COMPUTE -> CONVERT -> IDLE; start is accepted only in IDLE.
REQ-020 SHALL ignore start while busy, with no change to state or captured operands.
REQ-021 SHALL, on the accepting edge, capture both matrices, acc_en and relu_en, clear result_valid and overflow, and clear accumulators when acc_en=0.
REQ-022 SHALL skew-feed A rows from the left and B columns from the top; PE[i][j] sees A[i][k] and B[k][j] together at COMPUTE cycle k+i+j.
REQ-023 SHALL keep COMPUTE for exactly K_DEPTH+2*ARRAY_SIZE-2 cycles, injecting zeros beyond the matrix edges.
REQ-024 SHALL have each PE add the full signed product A*B, sign-extended to ACCUM_WIDTH, into its accumulator.
REQ-025 SHALL, in CONVERT, arithmetic-shift each accumulator right by FRAC_SHIFT and saturate it to the signed DATA_WIDTH range [0x8000, 0x7FFF] at the 16-bit defaults.
REQ-026 SHALL apply ReLU after saturation when relu_en was sampled high.
REQ-027 SHALL register result_flat, raise result_valid and pulse done on the edge leaving CONVERT, with latency start-edge-to-done = K_DEPTH+2*ARRAY_SIZE cycles (6 at the defaults).
REQ-028 SHALL hold result_flat, result_valid and overflow unchanged until the next accepted start.
REQ-029 SHALL deassert busy in the same cycle done is high; a start in that cycle is ignored, and one in the following cycle is accepted.
REQ-030 SHALL keep accumulators (not results) across runs, so acc_en=1 continues a K-tiled reduction.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-run, immediately set IDLE and drive busy, done, result_valid and overflow to 0, result_flat to 0, and all accumulators and skew registers to 0.
REQ-032 SHALL resume accepting start on the first rising edge after rst_n deasserts.

Verification
REQ-033 Identity: A=0x0400000000000400, B=0x40000040, acc_en=0 -> done 6 cycles after start, result_flat=0x0400000000000400, overflow=0.
REQ-034 Accumulate: repeat the identity run with acc_en=1 -> result_flat=0x0800000000000800.
REQ-035 Saturation: all A=0x7FFF, all B=0x7F -> every element 0x7FFF, overflow=1.
REQ-036 ReLU: A[0][0]=0xFC00, all other A=0, B identity; relu_en=0 gives C[0][0]=0xFC00; relu_en=1 gives C[0][0]=0x0000.
REQ-037 Handshake: start held high for 10 cycles -> exactly one done per accepted start; busy never drops mid-run.
REQ-038 Reset mid-COMPUTE -> all outputs 0 next sample; a fresh identity run afterwards gives 0x0400000000000400.
